qrisc32_if_prefetch: RTL and testbench
======================================

# qrisc32_if_prefetch

Parametrised instruction-fetch stage with a prefetch queue, replacing the single-register fetch path at the front of the qrisc32 pipeline. It issues sequential reads on the instruction Avalon master and buffers up to DEPTH fetched {pc, instruction} pairs. It presents one instruction per cycle to ID, holding the output under MEM back-pressure. An EX redirect flushes the queue and discards any read response still in flight.

## Interface
- DEPTH, 4: prefetch queue entries; power of two, 2..16.
- RESET_PC, 32'h0: first fetch address after reset.
- clk  in  1  pipeline clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- avm_address  out  32  read address, word aligned (bits [1:0] = 0).
- avm_rd  out  1  read request.
- avm_wait_req  in  1  slave not accepting; address and rd held while asserted.
- avm_data_r  in  32  read data, valid exactly one cycle after acceptance.
- pipe_stall  in  1  MEM-stage stall; hold outputs.
- new_address_valid  in  1  EX redirect strobe.
- new_address  in  32  redirect target.
- instruction  out  32  instruction to ID; 0 (nop) when invalid.
- pc  out  32  address of instruction.
- instr_valid  out  1  instruction/pc carry a real fetched word.

## Operation
- Acceptance: avm_rd & ~avm_wait_req. Each acceptance sets inflight for the next cycle; fetch_pc advances by 4.
- Credit rule: avm_rd = 1 only when count + inflight < DEPTH. The queue never overflows; no response is ever dropped for lack of space.
- Response cycle: if inflight & ~drop, push {issued_pc, avm_data_r}; otherwise discard.
- Output register: when ~pipe_stall, pop the head into instruction/pc with instr_valid = 1. If the queue is empty, load instruction = 0, instr_valid = 0, and hold pc. When pipe_stall, hold all three.
- Redirect (new_address_valid) has priority over pipe_stall and the credit rule:
  - empty the queue and set fetch_pc <= {new_address[31:2], 2'b00};
  - set drop for the response due next cycle;
  - load the output register with instruction = 0, instr_valid = 0;
  - deassert avm_rd in the redirect cycle; fetch resumes the following cycle.
- A redirect during avm_wait_req abandons the held request. This is legal because rd drops; the slave has not accepted it.
- Simultaneous push and pop in one cycle: count unchanged.
- FSM states:
  - S_RESET: one cycle after reset release, rd = 0; then S_FETCH.
  - S_FETCH: issue per the credit rule. Goes to S_HOLD on rd & wait_req, or S_FLUSH on redirect.
  - S_HOLD: address/rd frozen. Returns to S_FETCH on ~wait_req, or S_FLUSH on redirect.
  - S_FLUSH: rd = 0, one cycle; then S_FETCH.
- Reset mid-operation: queue emptied, inflight and drop cleared, FSM to S_RESET.

## Timing
- Reset values:
  - avm_address = RESET_PC, avm_rd = 0;
  - instruction = 0, pc = RESET_PC, instr_valid = 0;
  - queue count = 0, inflight = 0, drop = 0.
- Latency: read accepted in cycle N, data pushed at the end of N+1, instr_valid = 1 from cycle N+2 (no stall).
- Steady-state throughput: one instruction per cycle with DEPTH ≥ 2 and no wait_req.
- Redirect in cycle R: instr_valid = 0 in R+1; the first target read is issued in R+1; the target instruction is valid in R+3.
- Address arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

## Configuration
- QRISC32_IF_STATS_EN defined: adds output ports fetch_cnt[31:0] (accepted reads), flush_cnt[31:0] (redirects) and stall_cnt[31:0] (cycles in S_HOLD). All reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- qrisc32_pkg holds:
  - typedef fetch_state_e (S_RESET, S_FETCH, S_HOLD, S_FLUSH);
  - typedef packed struct if_entry_t {pc[31:0], instr[31:0]};
  - localparam NOP_INSTR = 32'h0.
- Sub-module qrisc32_if_fifo: synchronous FIFO of if_entry_t with push, pop, flush, count and empty; parametrised by DEPTH.

## Test plan
- Reset release, no wait_req, RESET_PC = 0: avm_address issues 0, 4, 8 on consecutive cycles. instr_valid rises two cycles after the first acceptance, with pc 0, 4, 8 paired to their data words.
- pipe_stall held 6 cycles with DEPTH = 4: at most 4 entries queued plus the output word, and avm_rd drops. Outputs are frozen; after release, pcs continue with no gaps or duplicates.
- avm_wait_req held 3 cycles on address 0x10: address stays 0x10 and rd stays 1 throughout; exactly one word is pushed for 0x10.
- new_address_valid = 1, new_address = 0x200 while a response is in flight: that response is discarded and instr_valid = 0 next cycle. The next valid pc is 0x200, three cycles after the redirect.
- Redirect coincident with pipe_stall and a full queue: the queue empties, the output becomes nop/invalid, and fetch resumes at the target.
- With QRISC32_IF_STATS_EN, 10 fetches, 2 redirects and 3 wait cycles: fetch_cnt = 10, flush_cnt = 2, stall_cnt = 3. After reset, all three read 0.

Source files
------------

// File: rtl/qrisc32_if_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : qrisc32_pkg
// Types and constants shared by the qrisc32 instruction-fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
package qrisc32_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage
`default_nettype wire

// File: rtl/qrisc32_if_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module : qrisc32_if_prefetch_if
// Avalon-MM read-only instruction bus between the fetch stage and memory.
// Rev    : 1.0  initial release
// ============================================================================
interface qrisc32_if_prefetch_if;

    logic [31:0] avm_address;
    logic        avm_rd;
    logic        avm_wait_req;
    logic [31:0] avm_data_r;

    modport master (
        output avm_address,
        output avm_rd,
        input  avm_wait_req,
        input  avm_data_r
    );

    modport slave (
        input  avm_address,
        input  avm_rd,
        output avm_wait_req,
        output avm_data_r
    );

endinterface
`default_nettype wire

// File: rtl/qrisc32_if_fifo.sv
`default_nettype none
// ============================================================================
// Module : qrisc32_if_fifo
// Synchronous FIFO of {pc, instr} entries with single-cycle flush.
// Rev    : 1.0  initial release
// ============================================================================
module qrisc32_if_fifo
    import qrisc32_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      i_push,
    input  wire if_entry_t i_data,
    input  wire logic      i_pop,
    input  wire logic      i_flush,
    output if_entry_t      o_head,
    output logic [CW-1:0]  o_count,
    output logic           o_empty
);

    if_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Flush wins over a same-cycle push so a discarded word never lands.
    assign w_do_push = i_push & ~i_flush;
    assign w_do_pop  = i_pop & ~i_flush & (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/qrisc32_if_prefetch.sv
`default_nettype none
// ============================================================================
// Module : qrisc32_if_prefetch
// Instruction fetch with a DEPTH-entry prefetch queue; optional statistics
// counters are enabled with the QRISC32_IF_STATS_EN macro.
// Rev    : 1.0  initial release
// ============================================================================
module qrisc32_if_prefetch
    import qrisc32_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    qrisc32_if_prefetch_if.master avm,
    input  wire logic             pipe_stall,
    input  wire logic             new_address_valid,
    input  wire logic [31:0]      new_address,
    output logic [31:0]           instruction,
    output logic [31:0]           pc,
    output logic                  instr_valid
`ifdef QRISC32_IF_STATS_EN
    ,
    output logic [31:0]           fetch_cnt,
    output logic [31:0]           flush_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  r_state;
    fetch_state_e  w_state_cur;
    fetch_state_e  w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_issued_pc;
    logic          r_inflight;
    logic          r_drop;
    logic          w_rd;
    logic          w_accept;
    logic          w_credit;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_occupancy;
    if_entry_t     w_head;
    if_entry_t     w_resp_entry;

    assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_credit    = (w_occupancy < (CW+1)'(DEPTH));

    // The redirect cycle itself is the flush cycle, so the target read
    // can issue on the very next cycle.
    always_comb begin
        w_state_cur = new_address_valid ? S_FLUSH : r_state;
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        case (w_state_cur)
            S_RESET: w_state_nxt = S_FETCH;
            S_FETCH: begin
                w_rd = w_credit;
                if (w_credit && avm.avm_wait_req) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                w_rd = 1'b1;
                if (!avm.avm_wait_req) w_state_nxt = S_FETCH;
            end
            S_FLUSH: w_state_nxt = S_FETCH;
            default: w_state_nxt = S_RESET;
        endcase
    end

    assign avm.avm_rd      = w_rd;
    assign avm.avm_address = r_fetch_pc;
    assign w_accept        = w_rd & ~avm.avm_wait_req;

    assign w_resp       = r_inflight & ~r_drop & ~new_address_valid;
    assign w_resp_entry = {r_issued_pc, avm.avm_data_r};
    assign w_pop        = ~new_address_valid & ~pipe_stall & ~w_empty;
    // An empty queue with a free output register lets the response bypass.
    assign w_push       = w_resp & (pipe_stall | ~w_empty);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RESET;
            r_fetch_pc  <= RESET_PC;
            r_issued_pc <= RESET_PC;
            r_inflight  <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_accept;
            r_drop     <= new_address_valid;
            if (w_accept) r_issued_pc <= r_fetch_pc;
            if (new_address_valid)
                r_fetch_pc <= {new_address[31:2], 2'b00};
            else if (w_accept)
                r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instruction <= NOP_INSTR;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
        end else if (new_address_valid) begin
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (!pipe_stall) begin
            if (!w_empty) begin
                instruction <= w_head.instr;
                pc          <= w_head.pc;
                instr_valid <= 1'b1;
            end else if (w_resp) begin
                instruction <= w_resp_entry.instr;
                pc          <= w_resp_entry.pc;
                instr_valid <= 1'b1;
            end else begin
                instruction <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
        end
    end

    qrisc32_if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_resp_entry),
        .i_pop   (w_pop),
        .i_flush (new_address_valid),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

`ifdef QRISC32_IF_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (w_accept)               fetch_cnt <= fetch_cnt + 32'd1;
            if (new_address_valid)      flush_cnt <= flush_cnt + 32'd1;
            if (w_state_cur == S_HOLD)  stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_qrisc32_if_prefetch.sv
`default_nettype none
// ============================================================================
// Module : tb_qrisc32_if_prefetch
// Directed scoreboard bench for the qrisc32 prefetching fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
module tb_qrisc32_if_prefetch;
    import qrisc32_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_stall;
    logic        new_address_valid;
    logic [31:0] new_address;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instr_valid;
`ifdef QRISC32_IF_STATS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] stall_cnt;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    if_entry_t   exp_q[$];
    if_entry_t   mon_e;

    logic        slv_acc  = 1'b0;
    logic [31:0] slv_addr = 32'h0;

    logic        p_stall = 1'b0;
    logic        p_redir = 1'b0;
    logic [31:0] p_instr = 32'h0;
    logic [31:0] p_pc    = 32'h0;
    logic        p_valid = 1'b0;

    qrisc32_if_prefetch_if bus();

    qrisc32_if_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .avm               (bus),
        .pipe_stall        (pipe_stall),
        .new_address_valid (new_address_valid),
        .new_address       (new_address),
        .instruction       (instruction),
        .pc                (pc),
        .instr_valid       (instr_valid)
`ifdef QRISC32_IF_STATS_EN
        ,
        .fetch_cnt         (fetch_cnt),
        .flush_cnt         (flush_cnt),
        .stall_cnt         (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16] ^ 16'h5A5A};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_q.push_back('{pc: a, instr: mem_word(a)});
    endtask

    // Memory slave: one-cycle read latency after acceptance.
    initial begin
        bus.avm_data_r = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            slv_acc  = bus.avm_rd && !bus.avm_wait_req;
            slv_addr = bus.avm_address;
            @(posedge clk);
            #1;
            bus.avm_data_r = slv_acc ? mem_word(slv_addr) : 32'hDEAD_BEEF;
        end
    end

    // Monitor: a freshly loaded valid word is checked against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            p_stall = 1'b0;
            p_redir = 1'b0;
        end else begin
            if (p_redir) begin
                chk("redirect_valid", 32'(instr_valid), 32'd0);
                chk("redirect_instr", instruction, NOP_INSTR);
            end else if (p_stall) begin
                chk("stall_hold_instr", instruction, p_instr);
                chk("stall_hold_pc", pc, p_pc);
                chk("stall_hold_valid", 32'(instr_valid), 32'(p_valid));
            end else if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got pc %h, expected no word", pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_pc", pc, mon_e.pc);
                    chk("sb_instr", instruction, mon_e.instr);
                end
            end else begin
                chk("empty_nop", instruction, NOP_INSTR);
            end
            p_stall = pipe_stall;
            p_redir = new_address_valid;
        end
        p_instr = instruction;
        p_pc    = pc;
        p_valid = instr_valid;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset             = 1'b1;
        pipe_stall        = 1'b0;
        new_address_valid = 1'b0;
        new_address       = 32'h0;
        bus.avm_wait_req  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_address", bus.avm_address, RESET_PC);
        chk("rst_rd", 32'(bus.avm_rd), 32'd0);
        chk("rst_instr", instruction, NOP_INSTR);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
`ifdef QRISC32_IF_STATS_EN
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int k = 0; k <= 48; k++) begin
            pipe_stall        = (k >= 14 && k <= 19) || (k >= 30 && k <= 36);
            bus.avm_wait_req  = (k >= 5 && k <= 7);
            new_address_valid = (k == 24) || (k == 36) || (k == 42);
            new_address       = (k == 24) ? 32'h0000_0200 :
                                (k == 36) ? 32'h0000_0303 : 32'hFFFF_FFF8;
            if (k == 0)
                for (int i = 0; i <= 12; i++) push_exp(32'(4 * i));
            if (k == 24)
                for (int i = 0; i <= 3; i++) push_exp(32'h200 + 32'(4 * i));
            if (k == 36)
                for (int i = 0; i <= 3; i++) push_exp(32'h300 + 32'(4 * i));
            if (k == 42) begin
                push_exp(32'hFFFF_FFF8);
                push_exp(32'hFFFF_FFFC);
                push_exp(32'h0000_0000);
                push_exp(32'h0000_0004);
            end

            @(negedge clk);
            if (k == 0)
                chk("s_reset_rd", 32'(bus.avm_rd), 32'd0);
            if (k >= 1 && k <= 3) begin
                chk("seq_rd", 32'(bus.avm_rd), 32'd1);
                chk("seq_addr", bus.avm_address, 32'(4 * (k - 1)));
            end
            if (k == 2) chk("latency_not_yet", 32'(instr_valid), 32'd0);
            if (k == 3) chk("latency_valid", 32'(instr_valid), 32'd1);
            if (k >= 5 && k <= 8) begin
                chk("wait_addr_held", bus.avm_address, 32'h10);
                chk("wait_rd_held", 32'(bus.avm_rd), 32'd1);
            end
            if (k == 7) chk("wait_bubble", 32'(instr_valid), 32'd0);
            if (k >= 17 && k <= 20) chk("credit_rd_low", 32'(bus.avm_rd), 32'd0);
            if (k == 21) begin
                chk("credit_resume_rd", 32'(bus.avm_rd), 32'd1);
                chk("credit_resume_addr", bus.avm_address, 32'h34);
            end
            if (k == 24) chk("redirect_rd_low", 32'(bus.avm_rd), 32'd0);
            if (k == 25) begin
                chk("target_rd", 32'(bus.avm_rd), 32'd1);
                chk("target_addr", bus.avm_address, 32'h200);
            end
            if (k == 26) chk("target_not_yet", 32'(instr_valid), 32'd0);
            if (k == 27) chk("target_valid", 32'(instr_valid), 32'd1);
            if (k >= 33 && k <= 36) chk("full_rd_low", 32'(bus.avm_rd), 32'd0);
            if (k == 37) begin
                chk("flush_full_rd", 32'(bus.avm_rd), 32'd1);
                chk("flush_full_addr", bus.avm_address, 32'h300);
            end
`ifdef QRISC32_IF_STATS_EN
            if (k == 38) begin
                chk("fetch_cnt", fetch_cnt, 32'd25);
                chk("flush_cnt", flush_cnt, 32'd2);
                chk("stall_cnt", stall_cnt, 32'd3);
            end
`endif
            if (k == 39) chk("flush_full_valid", 32'(instr_valid), 32'd1);
            if (k == 44) chk("wrap_addr_top", bus.avm_address, 32'hFFFF_FFFC);
            if (k == 45) chk("wrap_addr_zero", bus.avm_address, 32'h0);
            @(posedge clk);
            #1;
        end

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
